test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_test_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Test-structure sequencer: Wishbone-programmed settle/measure run counting oscillator edges.
// Define TEST_SEQUENCER_IRQ_EN to add the user_irq_o port and STATUS bit3 IRQ mask.
module test_sequencer #(
  parameter int NUM_TS = 16,
  parameter int CNT_W  = 24
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [$clog2(NUM_TS)-1:0] ts_sel_o,
  output logic                      ts_en_o,
  input  logic                      ts_osc_i
`ifdef TEST_SEQUENCER_IRQ_EN
  ,
  output logic                      user_irq_o
`endif
);

  localparam int SEL_W = $clog2(NUM_TS);
  localparam int TW    = (CNT_W > 16) ? CNT_W : 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DONE} state_t;
  state_t state_q, state_d;

  logic [SEL_W-1:0] sel_q;
  logic [15:0]      settle_q, settle_merged;
  logic [CNT_W-1:0] window_q, count_q;
  logic [31:0]      win_merged, rdata;
  logic [TW-1:0]    timer_q;
  logic [2:0]       reg_off;
  logic wb_access, wb_wr, ctrl_wr, status_wr, start_req, abort_req, busy;
  logic done_q, ovf_q, mask_rd;
  logic osc_s1, osc_s2, osc_s3, osc_edge;
  logic unused_bits;

  assign reg_off     = wbs_adr_i[4:2];
  assign wb_access   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wb_wr       = wb_access & wbs_we_i;
  assign ctrl_wr     = wb_wr & (reg_off == 3'd0) & wbs_sel_i[0];
  assign status_wr   = wb_wr & (reg_off == 3'd3) & wbs_sel_i[0];
  assign start_req   = ctrl_wr & wbs_dat_i[0];
  assign abort_req   = ctrl_wr & wbs_dat_i[1];
  assign busy        = (state_q != ST_IDLE);
  assign osc_edge    = osc_s2 & ~osc_s3;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], win_merged};

  // Byte-lane merge of incoming write data onto the current SETTLE/WINDOW values
  always_comb begin
    settle_merged = settle_q;
    win_merged    = 32'(window_q);
    for (int b = 0; b < 2; b++)
      if (wbs_sel_i[b]) settle_merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
    for (int b = 0; b < 4; b++)
      if (wbs_sel_i[b]) win_merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q    <= '0;
      settle_q <= '0;
      window_q <= '0;
    end else if (wb_wr && !busy) begin
      case (reg_off)
        3'd0:    if (wbs_sel_i[0]) sel_q <= wbs_dat_i[4 +: SEL_W];
        3'd1:    settle_q <= settle_merged;
        3'd2:    window_q <= win_merged[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      3'd0:    rdata[4 +: SEL_W] = sel_q;
      3'd1:    rdata[15:0] = settle_q;
      3'd2:    rdata[CNT_W-1:0] = window_q;
      3'd3:    rdata[3:0] = {mask_rd, ovf_q, done_q, busy};
      3'd4:    rdata[CNT_W-1:0] = count_q;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_access;
      wbs_dat_o <= (wb_access && !wbs_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      osc_s1 <= 1'b0;
      osc_s2 <= 1'b0;
      osc_s3 <= 1'b0;
    end else begin
      osc_s1 <= ts_osc_i;
      osc_s2 <= osc_s1;
      osc_s3 <= osc_s2;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Zero-length phases are skipped so SETTLE=0/WINDOW=0 never raise ts_en_o
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start_req) begin
          if (settle_q != '0)      state_d = ST_SETTLE;
          else if (window_q != '0) state_d = ST_MEASURE;
          else                     state_d = ST_DONE;
        end
      ST_SETTLE:  if (timer_q == TW'(1)) state_d = (window_q != '0) ? ST_MEASURE : ST_DONE;
      ST_MEASURE: if (timer_q == TW'(1)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_IDLE;
  end

  always_comb begin
    ts_en_o = 1'b0;
    case (state_q)
      ST_SETTLE, ST_MEASURE: ts_en_o = 1'b1;
      default:               ts_en_o = 1'b0;
    endcase
  end

  assign ts_sel_o = sel_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_d == ST_SETTLE && state_q != ST_SETTLE)        timer_q <= TW'(settle_q);
      else if (state_d == ST_MEASURE && state_q != ST_MEASURE) timer_q <= TW'(window_q);
      else if (timer_q != '0)                                  timer_q <= timer_q - 1'b1;

      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        count_q <= '0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        if (status_wr && wbs_dat_i[1]) done_q <= 1'b0;
        if (status_wr && wbs_dat_i[2]) ovf_q <= 1'b0;
        // Saturate rather than wrap; OVF records that an edge was lost
        if (state_q == ST_MEASURE && osc_edge) begin
          if (count_q == CNT_MAX) ovf_q <= 1'b1;
          else                    count_q <= count_q + 1'b1;
        end
        if (state_q == ST_DONE && !abort_req) done_q <= 1'b1;
      end
    end
  end

`ifdef TEST_SEQUENCER_IRQ_EN
  logic irq_mask_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)       irq_mask_q <= 1'b0;
    else if (status_wr) irq_mask_q <= wbs_dat_i[3];
  end

  assign mask_rd    = irq_mask_q;
  assign user_irq_o = done_q & irq_mask_q;
`else
  assign mask_rd = 1'b0;
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: randomized runs checked against an edge-window reference model.
// Build with TEST_SEQUENCER_IRQ_EN defined to also exercise the interrupt output.
module tb_test_sequencer;

  localparam int NUM_TS = 16;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] WMASK    = 32'((1 << CNT_W) - 1);
  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_SETTLE = 32'h4;
  localparam logic [31:0] A_WINDOW = 32'h8;
  localparam logic [31:0] A_STATUS = 32'hC;
  localparam logic [31:0] A_COUNT  = 32'h10;

  logic        clk = 1'b0;
  logic        rst, stb, cyc, we, osc;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack, ts_en;
  logic [31:0] rdat;
  logic [3:0]  ts_sel;
`ifdef TEST_SEQUENCER_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  int clk_cnt = 0;
  int last_acc = 0;
  int en_cycles = 0;
  int osc_mode = 0;
  int osc_half = 2;
  int rises[$];
  logic osc_next;
  logic [15:0] m_settle;
  logic [31:0] m_window;
  logic [3:0]  m_sel;

  test_sequencer #(.NUM_TS(NUM_TS), .CNT_W(CNT_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .ts_sel_o (ts_sel),
    .ts_en_o  (ts_en),
    .ts_osc_i (osc)
`ifdef TEST_SEQUENCER_IRQ_EN
    ,
    .user_irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Oscillator changes on the falling edge; each rise is logged with the preceding posedge index
  always @(negedge clk) begin
    case (osc_mode)
      1:       osc_next = ((clk_cnt / osc_half) % 2) == 1;
      2:       osc_next = ($urandom_range(1, 0) == 1);
      default: osc_next = 1'b0;
    endcase
    if (osc_next && !osc) rises.push_back(clk_cnt);
    osc = osc_next;
  end

  always @(posedge clk) begin
    #1;
    if (ts_en === 1'b1) en_cycles++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", clk_cnt);
    $fatal(1, "[TB] watchdog");
  end

  // A rise logged after posedge n is seen by the counter during cycle n+2
  function automatic int edges_in(int lo, int hi);
    int c = 0;
    foreach (rises[i]) if (rises[i] + 2 >= lo && rises[i] + 2 < hi) c++;
    return c;
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got = 1'b0;
    @(negedge clk);
    adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) last_acc = clk_cnt;
      if (ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL write_ack_timeout adr=%0h got no ack want ack", a);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got = 1'b0;
    d = 'x;
    @(negedge clk);
    adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin got = 1'b1; d = rdat; end
    end
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL read_ack_timeout adr=%0h got no ack want ack", a);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] st = 32'h1;
    for (int i = 0; i < 200 && st[0] !== 1'b0; i++) wb_read(A_STATUS, st);
    if (st[0] !== 1'b0) begin
      total++; bad++;
      $display("[TB] FAIL busy_timeout status=%0h want busy=0", st);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", ack); end
    total++; if (rdat !== 32'h0) begin bad++; $display("[TB] FAIL reset_dat got=%0h want=0", rdat); end
    total++; if (ts_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%b want=0", ts_en); end
    total++; if (ts_sel !== 4'h0) begin bad++; $display("[TB] FAIL reset_sel got=%0h want=0", ts_sel); end
    @(negedge clk);
    rst = 1'b0;
    m_settle = '0; m_window = '0; m_sel = '0;
    wb_read(A_STATUS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_status got=%0h want=0", rd); end
    wb_read(A_COUNT, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_count got=%0h want=0", rd); end
  endtask

  task automatic test_wishbone_ack();
    logic a0, a1, a2;
    @(negedge clk);
    adr = A_STATUS; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    #1 a0 = ack;
    @(posedge clk); #1 a1 = ack;
    @(posedge clk); #1 a2 = ack;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    total++; if (a0 !== 1'b0) begin bad++; $display("[TB] FAIL ack_early got=%b want=0", a0); end
    total++; if (a1 !== 1'b1) begin bad++; $display("[TB] FAIL ack_first got=%b want=1", a1); end
    total++; if (a2 !== 1'b0) begin bad++; $display("[TB] FAIL ack_held got=%b want=0", a2); end
  endtask

  task automatic test_registers();
    logic [31:0] d, rd, mw;
    logic [3:0]  s;
    for (int i = 0; i < 8; i++) begin
      d = $urandom; s = 4'($urandom_range(15, 0));
      wb_write(A_SETTLE, d, s);
      for (int b = 0; b < 2; b++) if (s[b]) m_settle[8*b +: 8] = d[8*b +: 8];
      d = $urandom; s = 4'($urandom_range(15, 0));
      wb_write(A_WINDOW, d, s);
      mw = m_window;
      for (int b = 0; b < 4; b++) if (s[b]) mw[8*b +: 8] = d[8*b +: 8];
      m_window = mw & WMASK;
      d = $urandom & ~32'h3; s = 4'($urandom_range(15, 0));
      wb_write(A_CTRL, d, s);
      if (s[0]) m_sel = d[7:4];
      wb_read(A_SETTLE, rd);
      total++; if (rd !== {16'h0, m_settle}) begin bad++; $display("[TB] FAIL reg_settle got=%0h want=%0h", rd, m_settle); end
      wb_read(A_WINDOW, rd);
      total++; if (rd !== m_window) begin bad++; $display("[TB] FAIL reg_window got=%0h want=%0h", rd, m_window); end
      wb_read(A_CTRL, rd);
      total++; if (rd !== {24'h0, m_sel, 4'h0}) begin bad++; $display("[TB] FAIL reg_ctrl got=%0h want=%0h", rd, {m_sel, 4'h0}); end
    end
    for (int off = 5; off < 8; off++) begin
      d = {27'($urandom), 5'(off * 4)};
      wb_write(d, $urandom, 4'hF);
      wb_read(d, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reg_unmapped off=%0d got=%0h want=0", off, rd); end
    end
    wb_read({27'($urandom), 5'h4}, rd);
    total++; if (rd !== {16'h0, m_settle}) begin bad++; $display("[TB] FAIL reg_alias got=%0h want=%0h", rd, m_settle); end
  endtask

  // One full run with the given programming; checks count, flags, enable length and select
  task automatic run_and_check(input string tag, input int s_len, input int w_len, input logic [3:0] tsel,
                               input int mode, input int half);
    logic [31:0] rd;
    int a, n, exp_cnt;
    logic exp_ovf;
    osc_mode = mode; osc_half = half;
    wb_write(A_SETTLE, 32'(s_len), 4'h3);
    wb_write(A_WINDOW, 32'(w_len), 4'hF);
    en_cycles = 0;
    wb_write(A_CTRL, {24'h0, tsel, 4'h1}, 4'h1);
    a = last_acc;
    wait_idle();
    n = edges_in(a + s_len, a + s_len + (w_len & CMAX));
    exp_cnt = (n > CMAX) ? CMAX : n;
    exp_ovf = (n > CMAX);
    wb_read(A_COUNT, rd);
    total++; if (rd !== 32'(exp_cnt)) begin bad++; $display("[TB] FAIL %s_count got=%0d want=%0d", tag, rd, exp_cnt); end
    wb_read(A_STATUS, rd);
    total++; if (rd[2:0] !== {exp_ovf, 2'b10}) begin bad++; $display("[TB] FAIL %s_status got=%0h want=%0h", tag, rd[2:0], {exp_ovf, 2'b10}); end
    total++; if (en_cycles !== s_len + (w_len & CMAX)) begin bad++; $display("[TB] FAIL %s_en_cycles got=%0d want=%0d", tag, en_cycles, s_len + (w_len & CMAX)); end
    total++; if (ts_sel !== tsel) begin bad++; $display("[TB] FAIL %s_sel got=%0h want=%0h", tag, ts_sel, tsel); end
  endtask

  task automatic test_basic_run();
    logic [31:0] rd;
    run_and_check("basic", 10, 100, 4'd5, 1, 2);
    wb_write(A_STATUS, 32'h2, 4'h1);
    wb_read(A_STATUS, rd);
    total++; if (rd[1] !== 1'b0) begin bad++; $display("[TB] FAIL done_clear got=%b want=0", rd[1]); end
  endtask

  task automatic test_zero_lengths();
    run_and_check("zero", 0, 0, 4'd2, 2, 1);
  endtask

  task automatic test_random_runs();
    for (int i = 0; i < 6; i++)
      run_and_check("rand", $urandom_range(12, 0), $urandom_range(255, 0),
                    4'($urandom_range(15, 0)), $urandom_range(2, 1), $urandom_range(4, 1));
    run_and_check("long", 0, 1000, 4'd1, 1, 1);
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int a, x, exp_cnt;
    osc_mode = 1; osc_half = 2;
    wb_write(A_SETTLE, 32'd5, 4'h3);
    wb_write(A_WINDOW, 32'd200, 4'hF);
    en_cycles = 0;
    wb_write(A_CTRL, 32'h31, 4'h1);
    a = last_acc;
    wb_write(A_SETTLE, 32'h77, 4'h3);
    wb_write(A_WINDOW, 32'h11, 4'hF);
    wb_write(A_CTRL, 32'h91, 4'h1);
    total++; if (ts_sel !== 4'd3) begin bad++; $display("[TB] FAIL busy_sel got=%0h want=3", ts_sel); end
    while (clk_cnt < a + 5 + 48) @(negedge clk);
    wb_write(A_CTRL, 32'h32, 4'h1);
    x = last_acc;
    total++; if (ts_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_en got=%b want=0", ts_en); end
    total++; if (en_cycles !== x - a) begin bad++; $display("[TB] FAIL abort_en_cycles got=%0d want=%0d", en_cycles, x - a); end
    exp_cnt = edges_in(a + 5, x);
    wb_read(A_STATUS, rd);
    total++; if (rd[2:0] !== 3'b000) begin bad++; $display("[TB] FAIL abort_status got=%0h want=0", rd[2:0]); end
    wb_read(A_COUNT, rd);
    total++; if (rd !== 32'(exp_cnt)) begin bad++; $display("[TB] FAIL abort_count got=%0d want=%0d", rd, exp_cnt); end
    wb_read(A_SETTLE, rd);
    total++; if (rd !== 32'd5) begin bad++; $display("[TB] FAIL busy_settle got=%0h want=5", rd); end
    wb_read(A_WINDOW, rd);
    total++; if (rd !== 32'd200) begin bad++; $display("[TB] FAIL busy_window got=%0h want=c8", rd); end
    en_cycles = 0;
    wb_write(A_CTRL, 32'h33, 4'h1);
    repeat (4) @(negedge clk);
    total++; if (en_cycles !== 0) begin bad++; $display("[TB] FAIL start_abort_en got=%0d want=0", en_cycles); end
    wb_read(A_COUNT, rd);
    total++; if (rd !== 32'(exp_cnt)) begin bad++; $display("[TB] FAIL start_abort_count got=%0d want=%0d", rd, exp_cnt); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    int a;
    osc_mode = 2;
    wb_write(A_SETTLE, 32'd2, 4'h3);
    wb_write(A_WINDOW, 32'd200, 4'hF);
    wb_write(A_CTRL, 32'h71, 4'h1);
    a = last_acc;
    while (clk_cnt < a + 40) @(negedge clk);
    @(negedge clk);
    adr = A_COUNT; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ack got=%b want=0", ack); end
    total++; if (rdat !== 32'h0) begin bad++; $display("[TB] FAIL midrst_dat got=%0h want=0", rdat); end
    total++; if (ts_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_en got=%b want=0", ts_en); end
    total++; if (ts_sel !== 4'h0) begin bad++; $display("[TB] FAIL midrst_sel got=%0h want=0", ts_sel); end
    @(negedge clk);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL midrst_late_ack got=%b want=0", ack); end
    osc_mode = 0;
    wb_read(A_COUNT, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_count got=%0h want=0", rd); end
    wb_read(A_SETTLE, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_settle got=%0h want=0", rd); end
    wb_read(A_WINDOW, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_window got=%0h want=0", rd); end
    wb_read(A_STATUS, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL midrst_status got=%0h want=0", rd); end
  endtask

`ifdef TEST_SEQUENCER_IRQ_EN
  task automatic test_irq();
    wb_write(A_STATUS, 32'h8, 4'h1);
    run_and_check("irq", 0, 3, 4'd4, 1, 1);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set got=%b want=1", irq); end
    wb_write(A_STATUS, 32'hA, 4'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear got=%b want=0", irq); end
  endtask
`endif

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0; osc = 1'b0;
    $display("[TB] starting test_sequencer bench");
    test_reset();
    test_wishbone_ack();
    test_registers();
    test_basic_run();
    test_zero_lengths();
    test_random_runs();
    test_abort();
    test_reset_mid_run();
`ifdef TEST_SEQUENCER_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
